painterengine_gpu_dma_writer: RTL

//  AXI4 full write master for the GPU DMA path; counterpart of the GPU DMA reader.
//  One of four client channels is selected by a one-hot router. Its 32-bit word stream is written to

---
 rtl/painterengine_gpu_dma_writer_if.sv | 35 +++
 rtl/painterengine_gpu_dma_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dma_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the GPU DMA writer and memory.
interface painterengine_gpu_dma_writer_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic        awid;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awvalid, awid, awsize, awburst, awlock, awcache, awprot, awqos,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, awid, awsize, awburst, awlock, awcache, awprot, awqos,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write master for the GPU DMA path: streams one routed client channel to memory
// as INCR bursts of up to 256 beats that never cross a 1 KB boundary.
module painterengine_gpu_dma_writer #(
  parameter int unsigned TIMEOUT_BIT = 18
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_reset,
  output logic                           o_wire_done,
  input  logic [127:0]                   i_wire_address,
  input  logic [127:0]                   i_wire_length,
  input  logic [3:0]                     i_wire_router,
  input  logic [127:0]                   i_wire_data,
  input  logic [3:0]                     i_wire_data_valid,
  output logic [3:0]                     o_wire_data_next,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  painterengine_gpu_dma_writer_if.master m_axi
);

  localparam int unsigned TW = TIMEOUT_BIT + 1;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ROUTER = 3'd1;
  localparam logic [2:0] ERR_PARAM  = 3'd2;
  localparam logic [2:0] ERR_AW     = 3'd3;
  localparam logic [2:0] ERR_W      = 3'd4;
  localparam logic [2:0] ERR_BRESP  = 3'd5;
  localparam logic [2:0] ERR_B      = 3'd6;

  typedef enum logic [2:0] {
    ST_ROUTING, ST_PARAM_CHECK, ST_CALC, ST_ADDR, ST_DATA, ST_RESP, ST_DONE, ST_ERROR
  } state_t;

  state_t          state_q, state_next;
  logic [2:0]      err_next, error_type_q;
  logic [1:0]      idx_q, route_idx;
  logic            route_ok;
  logic [31:0]     addr_q, len_q, offset_q, awaddr_q, remain;
  logic [8:0]      burst_q, burst_c, beat_q, room;
  logic [7:0]      line_pos;
  logic [TW-1:0]   tcount_q;
  logic            w_vld, aw_hs, w_hs, b_hs, w_last, timeout, waiting;
  logic            unused_bid;

  assign unused_bid = m_axi.bid;

  assign m_axi.awid    = 1'b0;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0010;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.wstrb   = 4'hF;

  assign w_vld   = i_wire_data_valid[idx_q];
  assign aw_hs   = (state_q == ST_ADDR) && m_axi.awready;
  assign w_hs    = (state_q == ST_DATA) && w_vld && m_axi.wready;
  assign b_hs    = (state_q == ST_RESP) && m_axi.bvalid;
  assign w_last  = (beat_q == burst_q - 9'd1);
  assign timeout = tcount_q[TIMEOUT_BIT];
  assign waiting = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);

  // Burst length: the words left in the current 1 KB line, capped by words left to send.
  assign line_pos = addr_q[9:2] + offset_q[7:0];
  assign room     = 9'd256 - {1'b0, line_pos};
  assign remain   = len_q - offset_q;
  assign burst_c  = (remain < 32'(room)) ? remain[8:0] : room;

  always_comb begin
    route_ok  = 1'b1;
    route_idx = 2'd0;
    case (i_wire_router)
      4'b0001: route_idx = 2'd0;
      4'b0010: route_idx = 2'd1;
      4'b0100: route_idx = 2'd2;
      4'b1000: route_idx = 2'd3;
      default: route_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) state_q <= ST_ROUTING;
    else              state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    err_next   = ERR_NONE;
    case (state_q)
      ST_ROUTING: begin
        if (route_ok) state_next = ST_PARAM_CHECK;
        else begin
          state_next = ST_ERROR;
          err_next   = ERR_ROUTER;
        end
      end
      ST_PARAM_CHECK: begin
        if ((addr_q[1:0] != 2'b00) || (len_q == 32'd0)) begin
          state_next = ST_ERROR;
          err_next   = ERR_PARAM;
        end else begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: state_next = ST_ADDR;
      ST_ADDR: begin
        if (timeout) begin
          state_next = ST_ERROR;
          err_next   = ERR_AW;
        end else if (aw_hs) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          state_next = ST_ERROR;
          err_next   = ERR_W;
        end else if (w_hs && w_last) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (timeout) begin
          state_next = ST_ERROR;
          err_next   = ERR_B;
        end else if (b_hs) begin
          if (m_axi.bresp != 2'b00) begin
            state_next = ST_ERROR;
            err_next   = ERR_BRESP;
          end else if (({1'b0, offset_q} + 33'(burst_q)) >= {1'b0, len_q}) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      default: state_next = state_q;
    endcase
  end

  // Transfer datapath: channel latch, burst bookkeeping, stall counter and sticky error code.
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      idx_q        <= 2'd0;
      addr_q       <= 32'd0;
      len_q        <= 32'd0;
      offset_q     <= 32'd0;
      awaddr_q     <= 32'd0;
      burst_q      <= 9'd0;
      beat_q       <= 9'd0;
      tcount_q     <= '0;
      error_type_q <= ERR_NONE;
    end else begin
      case (state_q)
        ST_ROUTING: begin
          if (route_ok) begin
            idx_q  <= route_idx;
            addr_q <= i_wire_address[{route_idx, 5'd0} +: 32];
            len_q  <= i_wire_length[{route_idx, 5'd0} +: 32];
          end
        end
        ST_PARAM_CHECK: offset_q <= 32'd0;
        ST_CALC: begin
          burst_q  <= burst_c;
          awaddr_q <= addr_q + {offset_q[29:0], 2'b00};
        end
        ST_ADDR: if (aw_hs) beat_q <= 9'd0;
        ST_DATA: if (w_hs) beat_q <= beat_q + 9'd1;
        ST_RESP: if (b_hs && (m_axi.bresp == 2'b00)) offset_q <= offset_q + 32'(burst_q);
        default: ;
      endcase

      if (waiting && !(aw_hs || w_hs || b_hs)) tcount_q <= tcount_q + TW'(1);
      else                                     tcount_q <= '0;

      if ((state_next == ST_ERROR) && (state_q != ST_ERROR)) error_type_q <= err_next;
    end
  end

  // Bus outputs are decoded from the registered state; W follows the selected source directly.
  always_comb begin
    m_axi.awvalid     = 1'b0;
    m_axi.awaddr      = 32'd0;
    m_axi.awlen       = 8'd0;
    m_axi.wvalid      = 1'b0;
    m_axi.wdata       = 32'd0;
    m_axi.wlast       = 1'b0;
    m_axi.bready      = 1'b0;
    o_wire_data_next  = 4'b0000;
    o_wire_done       = 1'b0;
    o_wire_error      = 1'b0;
    o_wire_error_type = error_type_q;
    case (state_q)
      ST_ADDR: begin
        m_axi.awvalid = 1'b1;
        m_axi.awaddr  = awaddr_q;
        m_axi.awlen   = 8'(burst_q - 9'd1);
      end
      ST_DATA: begin
        m_axi.wvalid            = w_vld;
        m_axi.wdata             = i_wire_data[{idx_q, 5'd0} +: 32];
        m_axi.wlast             = w_last;
        o_wire_data_next[idx_q] = w_vld & m_axi.wready;
      end
      ST_RESP:  m_axi.bready = 1'b1;
      ST_DONE:  o_wire_done  = 1'b1;
      ST_ERROR: o_wire_error = 1'b1;
      default: ;
    endcase
  end

endmodule
